// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: valid/ready hand-off of instruction and PC from fetch to decode,
// with an optional two-entry skid buffer, flush-to-bubble and a saturating stall counter.
module if_id_pipe_reg #(
    parameter int unsigned        INST_W   = 16,
    parameter int unsigned        ADDR_W   = 13,
    parameter logic [INST_W-1:0]  NOP_INST = {INST_W{1'b0}},
    parameter bit                 SKID_EN  = 1'b1,
    parameter int unsigned        CNT_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [INST_W-1:0]   main_inst_q, main_inst_d;
    logic [ADDR_W-1:0]   main_pc_q, main_pc_d;
    logic [INST_W-1:0]   skid_inst_q, skid_inst_d;
    logic [ADDR_W-1:0]   skid_pc_q, skid_pc_d;
    logic                in_ready_q, in_ready_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic                accept_s;
    logic                deliver_s;
    logic                out_valid_s;

    assign out_valid_s = (state_q != ST_EMPTY);
    // Without the skid entry, a full stage can only take a new word when decode drains it.
    assign in_ready    = SKID_EN ? in_ready_q : (!out_valid_s || out_ready);
    assign accept_s    = in_valid && in_ready;
    assign deliver_s   = out_valid_s && out_ready;

    assign out_valid   = out_valid_s;
    assign out_inst    = main_inst_q;
    assign out_pc      = main_pc_q;
    assign stall_cnt   = stall_q;

    // Occupancy decode from the current state.
    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            ST_EMPTY: occupancy = 2'd0;
            ST_FULL:  occupancy = 2'd1;
            ST_SKID:  occupancy = 2'd2;
            default:  occupancy = 2'd0;
        endcase
    end

    // Next-state, datapath and counter logic.
    always_comb begin
        state_d     = state_q;
        main_inst_d = main_inst_q;
        main_pc_d   = main_pc_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_d     = ST_FULL;
                    main_inst_d = in_inst;
                    main_pc_d   = in_pc;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (accept_s && deliver_s) begin
                    main_inst_d = in_inst;
                    main_pc_d   = in_pc;
                end else if (accept_s) begin
                    state_d     = ST_SKID;
                    skid_inst_d = in_inst;
                    skid_pc_d   = in_pc;
                end else if (deliver_s) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            ST_SKID: begin
                if (deliver_s) begin
                    state_d     = ST_FULL;
                    main_inst_d = skid_inst_q;
                    main_pc_d   = skid_pc_q;
                end else begin
                    state_d = ST_SKID;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            state_d = state_d;
        end

        // An empty stage presents a bubble rather than whatever was last held.
        if (state_d == ST_EMPTY) begin
            main_inst_d = NOP_INST;
            main_pc_d   = {ADDR_W{1'b0}};
        end else begin
            main_inst_d = main_inst_d;
        end

        in_ready_d = (state_d != ST_SKID);

        if (out_valid_s && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_d = stall_q;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_inst_q <= NOP_INST;
            main_pc_q   <= {ADDR_W{1'b0}};
            skid_inst_q <= NOP_INST;
            skid_pc_q   <= {ADDR_W{1'b0}};
            in_ready_q  <= 1'b1;
            stall_q     <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            main_inst_q <= main_inst_d;
            main_pc_q   <= main_pc_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
            in_ready_q  <= in_ready_d;
            stall_q     <= stall_d;
        end
    end

endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
Parametrised IF/ID pipeline register between instruction fetch (read_ROM output plus fetch address) and decode.
- Carries instruction and PC in a valid/ready handshake.
- Optional 2-entry skid buffer, so the fetch side sees a registered ready and never loses an instruction when decode stalls.
- Synchronous flush for branch/jump redirects, which injects a NOP bubble.
- Saturating stall-cycle counter for performance debug.

Parameters:
INST_W, 16, instruction width in bits
ADDR_W, 13, fetch address (PC) width in bits
NOP_INST, {INST_W{1'b0}}, instruction value driven on out_inst whenever out_valid=0
SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready
CNT_W, 16, stall counter width

Ports:
clock  in  1  rising-edge clock, single clock domain
reset  in  1  synchronous, active-high
in_valid  in  1  fetch offers an instruction
in_ready  out  1  stage can accept this cycle
in_inst  in  INST_W  fetched instruction
in_pc  in  ADDR_W  address of in_inst
out_valid  out  1  decode-side instruction valid
out_ready  in  1  decode accepts this cycle
out_inst  out  INST_W  instruction to decode
out_pc  out  ADDR_W  PC to decode
flush  in  1  discard all held instructions
occupancy  out  2  entries held (0..2)
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

Behaviour:
- All state updates on the rising edge of clock. No negedge logic.
- Handshake events:
  - Accept = in_valid & in_ready.
  - Deliver = out_valid & out_ready.
  - Data is held stable on out_* while out_valid=1 and out_ready=0.
- Reset (has priority over all other inputs):
  - Next cycle: out_valid=0, out_inst=NOP_INST, out_pc=0, occupancy=0, stall_cnt=0.
  - in_ready=1 the cycle after reset deasserts.
  - Reset mid-transfer drops both entries.
- SKID_EN=1: states EMPTY (occ 0), FULL (occ 1, main only), SKID (occ 2, main+skid). in_ready = (state != SKID), registered.
  - EMPTY: accept -> FULL; input loaded into main.
  - FULL, accept and deliver -> FULL; main <= input.
  - FULL, accept, no deliver -> SKID; skid <= input.
  - FULL, deliver, no accept -> EMPTY.
  - SKID, deliver -> FULL; main <= skid. in_ready is 0, so no accept is possible.
  - Order is strictly FIFO. Output is always main.
- SKID_EN=0: depth 1.
  - in_ready = !out_valid | out_ready, combinational.
  - occupancy is never 2.
- Flush (priority below reset, above handshake):
  - Next cycle out_valid=0 and occupancy=0, regardless of accept or deliver in the same cycle.
  - An instruction accepted in the flush cycle is discarded; the fetch side still sees it as accepted.
  - A deliver in the flush cycle still counts for decode (decode sees out_valid=1 that cycle).
  - stall_cnt is not cleared by flush.
- Invalid output:
  - out_valid=0 drives out_inst=NOP_INST and out_pc=0, never stale data.
- stall_cnt:
  - Increments by 1 each cycle out_valid & !out_ready.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Cleared only by reset.
- Latency: 1 cycle from accept to out_valid when EMPTY. Throughput: 1 instruction/cycle with out_ready held high.
- X on in_inst or in_pc while in_valid=0 must never propagate to out_*.

Test Plan:
- Reset then stream: reset 2 cycles, out_ready=1, push PCs 0..4 with inst 16'hA000+pc back-to-back -> out_valid from cycle 1 after the first accept, values in order, 1 per cycle, in_ready stays 1, occupancy=1.
- Backpressure skid (SKID_EN=1): out_ready=0 while pushing 16'h1111@pc1 and 16'h2222@pc2 -> occupancy=2, in_ready=0, out holds 1111/pc1. Then out_ready=1 -> 1111 then 2222 on consecutive cycles, in_ready returns to 1 one cycle after the first deliver. stall_cnt equals the stalled cycle count.
- Flush with simultaneous accept: occupancy=2, assert flush with in_valid=1 and inst 16'h3333 -> next cycle out_valid=0, out_inst=NOP_INST, out_pc=0, occupancy=0, and 3333 never appears.
- SKID_EN=0 build: out_ready=0 with occupancy=1 -> in_ready=0 combinationally. Raise out_ready and in_valid in the same cycle -> deliver and accept together, new data appears next cycle.
- Counter saturation (CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15. Apply flush -> stall_cnt stays 15. Apply reset -> stall_cnt=0.
- Reset mid-stall: occupancy=2, assert reset 1 cycle -> next cycle out_valid=0, occupancy=0, in_ready=1, and no held data reappears.
